ai_player_ctl: RTL and testbench
================================

AI_PLAYER_CTL -- requirements
Module: ai_player_ctl

Interface
REQ-001 SHALL have parameter PLAYERS_RADIUS, default 20, player puck radius in pixels.
REQ-002 SHALL have parameter RADIUS_BALL, default 10, ball radius in pixels.
REQ-003 SHALL have parameters MID_X 512, X_MIN 532, X_MAX 1003, Y_MIN 20, Y_MAX 747, giving the centre line and the player-2 motion bounds.
REQ-004 SHALL have parameters HOME_X 900 and HOME_Y 362, giving the player-2 home position.
REQ-005 SHALL have parameter STEP_DIV, default 250000, giving clock cycles per movement step (minimum 1).
REQ-006 clk_in  input  1  sole clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 enable  input  1  AI active when high.
REQ-009 xpos_ball, ypos_ball  input  12 each  current ball centre.
REQ-010 xpos_player_2, ypos_player_2  output  12 each  registered player-2 centre.
REQ-011 state  output  2  registered FSM state: IDLE=0, TRACK=1, ATTACK=2, RETURN=3.
REQ-012 moving  output  1  registered; high when the player position differs from the current target.

Function
REQ-013 Step counter SHALL count 0..STEP_DIV-1, free-running and wrapping; tick SHALL be asserted in the cycle the count equals STEP_DIV-1.
REQ-014 On a tick, each axis SHALL move exactly 1 pixel toward its target, or hold if already equal; both axes SHALL update in the same cycle; position SHALL NOT change without a tick.
REQ-015 Targets SHALL be clamped: x to [X_MIN, X_MAX], y to [Y_MIN, Y_MAX]; the player position SHALL therefore never leave those bounds.
REQ-016 Offset and difference arithmetic SHALL use at least 13 bits so that no 12-bit wrap occurs.
REQ-017 Target per state:
- IDLE: current position (hold).
- TRACK: (HOME_X, ypos_ball).
- ATTACK: (xpos_ball+RADIUS_BALL+PLAYERS_RADIUS, ypos_ball).
- RETURN: (HOME_X, HOME_Y).
REQ-018 Contact SHALL be defined as |xpos_player_2-xpos_ball| <= RADIUS_BALL+PLAYERS_RADIUS and |ypos_player_2-ypos_ball| <= RADIUS_BALL+PLAYERS_RADIUS.
REQ-019 Transitions SHALL be evaluated every cycle and applied in the order below (first match wins):
1. enable=0 -> IDLE from any state.
2. IDLE with enable=1 -> RETURN.
3. ATTACK with contact or xpos_ball < MID_X -> RETURN.
4. TRACK with xpos_ball >= MID_X -> ATTACK.
5. RETURN with position equal to (HOME_X, HOME_Y) -> TRACK.
6. Otherwise stay in the current state.
REQ-020 A state change and a tick in the same cycle: the move SHALL use the target of the pre-transition state.
REQ-021 moving SHALL reflect the position and target registered in the same cycle; it SHALL be 0 in IDLE.

Reset
REQ-022 While rst_n=0 at a clock edge: xpos_player_2=HOME_X, ypos_player_2=HOME_Y, state=IDLE, moving=0, step counter=0.
REQ-023 Reset asserted mid-move or mid-state SHALL take effect at the next edge; no partial step SHALL be retained.

Configuration
REQ-024 Macro AI_ATTACK_EN:
- Defined: ATTACK state and transition rule 4 SHALL be present.
- Undefined: rule 4 SHALL be removed; state SHALL never equal 2; the block SHALL only defend (TRACK/RETURN).

Verification (STEP_DIV=2)
REQ-025 Reset: rst_n=0 for 3 cycles -> outputs (900,362), state=0, moving=0.
REQ-026 enable=1, ball (300,100) -> RETURN for 1 cycle, then TRACK; ypos_player_2 decrements 1 every 2 cycles to 100; x stays 900.
REQ-027 AI_ATTACK_EN defined, ball (700,362) -> ATTACK; xpos_player_2 decrements toward 730; contact at x<=730 -> RETURN, then back to (900,362) and TRACK.
REQ-028 AI_ATTACK_EN undefined, ball (700,362) -> state remains TRACK; x stays 900.
REQ-029 Ball y=5 in TRACK -> ypos_player_2 stops at 20; ball x=1000 in ATTACK -> target x clamps to 1003.
REQ-030 enable dropped mid-move -> IDLE on the next edge; position frozen; moving=0.

Source files
------------

// File: rtl/ai_player_ctl.sv
// ai_player_ctl: player-2 puck controller.
// A free-running step counter paces motion; a 4-state FSM picks the target,
// and the puck moves one pixel per axis toward it on every step tick.
// Build option: define AI_ATTACK_EN to allow TRACK -> ATTACK (chase the ball).
// Without it the block only defends (TRACK/RETURN).
module ai_player_ctl #(
    parameter int PLAYERS_RADIUS = 20,
    parameter int RADIUS_BALL    = 10,
    parameter int MID_X          = 512,
    parameter int X_MIN          = 532,
    parameter int X_MAX          = 1003,
    parameter int Y_MIN          = 20,
    parameter int Y_MAX          = 747,
    parameter int HOME_X         = 900,
    parameter int HOME_Y         = 362,
    parameter int STEP_DIV       = 250000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] xpos_ball,
    input  logic [11:0] ypos_ball,
    output logic [11:0] xpos_player_2,
    output logic [11:0] ypos_player_2,
    output logic [1:0]  state,
    output logic        moving
);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ATTACK = 2'd2, RETURN = 2'd3} state_t;
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } pos_t;
    // 14-bit signed keeps ball+reach and position differences clear of 12-bit wrap
    typedef logic signed [13:0] s14_t;

    localparam int   CW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);
    localparam s14_t REACH_S = s14_t'(RADIUS_BALL + PLAYERS_RADIUS);
    localparam s14_t XMIN_S  = s14_t'(X_MIN);
    localparam s14_t XMAX_S  = s14_t'(X_MAX);
    localparam s14_t YMIN_S  = s14_t'(Y_MIN);
    localparam s14_t YMAX_S  = s14_t'(Y_MAX);
    localparam logic [11:0] MID_X12  = 12'(MID_X);
    localparam logic [11:0] HOME_X12 = 12'(HOME_X);
    localparam logic [11:0] HOME_Y12 = 12'(HOME_Y);

    function automatic s14_t ext(input logic [11:0] v);
        return s14_t'({2'b00, v});
    endfunction

    function automatic logic [11:0] clampv(input s14_t v, input s14_t lo, input s14_t hi);
        s14_t r;
        r = v;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        return 12'(r);
    endfunction

    function automatic logic [11:0] step1(input logic [11:0] p, input logic [11:0] t);
        if (p < t)      return p + 12'd1;
        else if (p > t) return p - 12'd1;
        else            return p;
    endfunction

    function automatic s14_t absd(input logic [11:0] a, input logic [11:0] b);
        s14_t d;
        d = ext(a) - ext(b);
        return (d < 0) ? -d : d;
    endfunction

    state_t        st, st_nxt;
    pos_t          pos, pos_nxt, home, trk, atk, tgt_cur, tgt_nxt;
    logic [CW-1:0] cnt;
    logic          tick, contact;

    function automatic pos_t target_of(input state_t s, input pos_t cur, input pos_t t_trk,
                                       input pos_t t_atk, input pos_t t_home);
        case (s)
            TRACK:   return t_trk;
            ATTACK:  return t_atk;
            RETURN:  return t_home;
            default: return cur;
        endcase
    endfunction

    assign tick          = (cnt == CNT_MAX);
    assign home          = '{x: HOME_X12, y: HOME_Y12};
    assign trk           = '{x: clampv(ext(HOME_X12), XMIN_S, XMAX_S),
                             y: clampv(ext(ypos_ball), YMIN_S, YMAX_S)};
    assign atk           = '{x: clampv(ext(xpos_ball) + REACH_S, XMIN_S, XMAX_S),
                             y: clampv(ext(ypos_ball), YMIN_S, YMAX_S)};
    assign contact       = (absd(pos.x, xpos_ball) <= REACH_S) &&
                           (absd(pos.y, ypos_ball) <= REACH_S);
    assign xpos_player_2 = pos.x;
    assign ypos_player_2 = pos.y;
    assign state         = st;

    // next state, prioritised; enable low always wins
    always_comb begin
        st_nxt = st;
        if (!enable) begin
            st_nxt = IDLE;
        end else begin
            case (st)
                IDLE:   st_nxt = RETURN;
                ATTACK: if (contact || xpos_ball < MID_X12) st_nxt = RETURN;
                TRACK: begin
`ifdef AI_ATTACK_EN
                    if (xpos_ball >= MID_X12) st_nxt = ATTACK;
`else
                    st_nxt = TRACK;
`endif
                end
                RETURN: if (pos == home) st_nxt = TRACK;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // a tick moves toward the pre-transition target; moving looks at the post-edge state
    always_comb begin
        tgt_cur = target_of(st, pos, trk, atk, home);
        pos_nxt = pos;
        if (tick) begin
            pos_nxt.x = step1(pos.x, tgt_cur.x);
            pos_nxt.y = step1(pos.y, tgt_cur.y);
        end
        tgt_nxt = target_of(st_nxt, pos_nxt, trk, atk, home);
    end

    // step counter, FSM state, position and moving flag
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt    <= '0;
            st     <= IDLE;
            pos    <= home;
            moving <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            st     <= st_nxt;
            pos    <= pos_nxt;
            moving <= (st_nxt != IDLE) && (pos_nxt != tgt_nxt);
        end
    end

endmodule

// File: tb/tb_ai_player_ctl.sv
// Scoreboard bench for ai_player_ctl with STEP_DIV=2.
// The driver pushes hand-computed expectations tagged with a cycle number;
// the monitor pops and compares them on the falling edge of that cycle.
module tb_ai_player_ctl;

    logic        clk_in = 1'b0;
    logic        rst_n, enable;
    logic [11:0] xpos_ball, ypos_ball, xpos_player_2, ypos_player_2;
    logic [1:0]  state;
    logic        moving;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic [11:0] x, y;
        logic [1:0]  st;
        logic        mv;
        bit          cx, cy, cm;
    } exp_t;
    exp_t q[$];

    ai_player_ctl #(.STEP_DIV(2)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .enable(enable),
        .xpos_ball(xpos_ball), .ypos_ball(ypos_ball),
        .xpos_player_2(xpos_player_2), .ypos_player_2(ypos_player_2),
        .state(state), .moving(moving)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

    // monitor: compare every expectation due at or before this cycle
    always @(negedge clk_in) begin
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            exp_t e;
            bit   ok;
            e = q.pop_front();
            checks++;
            ok = (state === e.st) && (!e.cx || xpos_player_2 === e.x) &&
                 (!e.cy || ypos_player_2 === e.y) && (!e.cm || moving === e.mv);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got x=%0d y=%0d st=%0d mv=%0d, want x=%0d%s y=%0d%s st=%0d mv=%0d%s",
                         e.nm, xpos_player_2, ypos_player_2, state, moving,
                         e.x, e.cx ? "" : "(ignored)", e.y, e.cy ? "" : "(ignored)",
                         e.st, e.mv, e.cm ? "" : "(ignored)");
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [11:0] x, input logic [11:0] y,
                              input logic [1:0] st, input logic mv,
                              input bit cx = 1, input bit cy = 1, input bit cm = 1);
        exp_t e;
        e.cyc = cyc_cnt; e.nm = nm; e.x = x; e.y = y; e.st = st; e.mv = mv;
        e.cx = cx; e.cy = cy; e.cm = cm;
        q.push_back(e);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, state=%0d want %0d", nm, n, state, s);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; xpos_ball = 12'd300; ypos_ball = 12'd100;
        cycles(3);
        expect_now("reset", 900, 362, 0, 0);

        // enable: IDLE -> RETURN (already home) -> TRACK, y walks down every 2nd edge
        rst_n = 1'b1; enable = 1'b1;
        cycles(1); expect_now("idle_to_return", 900, 362, 3, 0);
        cycles(1); expect_now("return_to_track", 900, 362, 1, 1);
        cycles(1); expect_now("track_no_tick", 900, 362, 1, 1);
        cycles(1); expect_now("track_step1", 900, 361, 1, 1);
        cycles(1); expect_now("track_hold", 900, 361, 1, 1);
        cycles(1); expect_now("track_step2", 900, 360, 1, 1);
        cycles(594); expect_now("track_y100", 900, 100, 1, 0);

        // ball below the field: y clamps at Y_MIN
        ypos_ball = 12'd5;
        cycles(200); expect_now("clamp_ymin", 900, 20, 1, 0);

        ypos_ball = 12'd362;
        cycles(720); expect_now("track_y362", 900, 362, 1, 0);

        xpos_ball = 12'd700;
`ifdef AI_ATTACK_EN
        cycles(1); expect_now("enter_attack", 900, 362, 2, 1, 0, 1, 1);
        wait_state(3, 600, "wait_contact");
        expect_now("contact_return", 730, 362, 3, 1);
        wait_state(1, 600, "wait_home");
        expect_now("home_track", 900, 362, 1, 0);
        xpos_ball = 12'd1000; ypos_ball = 12'd100;
        cycles(1); expect_now("reattack", 900, 362, 2, 1, 0, 0, 1);
        cycles(300); expect_now("clamp_xmax", 1003, 0, 2, 1, 1, 0, 1);
`else
        cycles(20);  expect_now("no_attack", 900, 362, 1, 0);
        cycles(200); expect_now("no_attack_late", 900, 362, 1, 0);
`endif

        // second run from reset: drop enable mid-move, then reset mid-move
        rst_n = 1'b0; xpos_ball = 12'd300; ypos_ball = 12'd100;
        cycles(3); expect_now("reset2", 900, 362, 0, 0);
        rst_n = 1'b1;
        cycles(10); expect_now("pre_drop", 900, 358, 1, 1);
        enable = 1'b0;
        cycles(1); expect_now("drop_idle", 900, 358, 0, 0);
        cycles(6); expect_now("idle_frozen", 900, 358, 0, 0);
        enable = 1'b1;
        cycles(1); expect_now("reenable_return", 900, 358, 3, 1);
        cycles(2); expect_now("return_step", 900, 359, 3, 1);
        rst_n = 1'b0;
        cycles(1); expect_now("reset_midmove", 900, 362, 0, 0);
        rst_n = 1'b1; enable = 1'b0;
        cycles(4); expect_now("post_reset_idle", 900, 362, 0, 0);

        cycles(2);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
